// File: rtl/acc_shift_pkg.sv
// Shared command and state encodings for the accumulator/shift register.
package acc_shift_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHR  = 3'b010,
        OP_SAR  = 3'b011,
        OP_SHL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } st_t;

endpackage

// File: rtl/acc_shift_step.sv
// One-position shift/rotate of the data field; extension bit q[W] always passes through.
// Purely combinational, zero latency; no flow control.
module acc_shift_step
    import acc_shift_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W:0] q_i,
    input  op_t        op_i,
    input  logic       ser_i,
    output logic [W:0] q_o,
    output logic       ser_o
);

    always_comb begin
        q_o   = q_i;
        ser_o = 1'b0;
        unique case (op_i)
            OP_SHR: begin
                q_o   = {q_i[W], 1'b0, q_i[W-1:1]};
                ser_o = q_i[0];
            end
            OP_SAR: begin
                q_o   = {q_i[W], q_i[W-1], q_i[W-1:1]};
                ser_o = q_i[0];
            end
            OP_SHL: begin
                q_o   = {q_i[W], q_i[W-2:0], ser_i};
                ser_o = q_i[W-1];
            end
            OP_ROR: begin
                q_o   = {q_i[W], q_i[0], q_i[W-1:1]};
                ser_o = q_i[0];
            end
            OP_ROL: begin
                q_o   = {q_i[W], q_i[W-2:0], q_i[W-1]};
                ser_o = q_i[W-1];
            end
            default: begin
                q_o   = q_i;
                ser_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_shift_reg.sv
// W+1-bit accumulator with load/clear and N-position shifts at one position per clock.
// First step at the accept edge, done one cycle after the last step; start ignored while busy.
module acc_shift_reg
    import acc_shift_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [W:0]       d_in,
    input  logic             ser_in,
    output logic [W:0]       q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    st_t              state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       q_q, q_d;
    logic             ser_q, ser_d;
    logic             done_q, done_d;

    op_t              op_in;
    op_t              step_op;
    logic [CNT_W-1:0] neff;
    logic [W:0]       step_q;
    logic             step_ser;

    assign op_in   = op_t'(op);
    assign neff    = (amt > CNT_W'(W)) ? CNT_W'(W) : amt;
    // The step unit sees the live op only while idle; in SHIFT it replays the latched op.
    assign step_op = (state_q == SHIFT) ? op_q : op_in;

    acc_shift_step #(.W(W)) u_step (
        .q_i   (q_q),
        .op_i  (step_op),
        .ser_i (ser_in),
        .q_o   (step_q),
        .ser_o (step_ser)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (op_in)
                        OP_NOP: done_d = 1'b1;
                        OP_LOAD: begin
                            q_d    = d_in;
                            done_d = 1'b1;
                        end
                        OP_CLR: begin
                            q_d    = '0;
                            ser_d  = 1'b0;
                            done_d = 1'b1;
                        end
                        default: begin
                            if (neff == '0) begin
                                done_d = 1'b1;
                            end else begin
                                q_d   = step_q;
                                ser_d = step_ser;
                                cnt_d = neff - CNT_W'(1);
                                op_d  = op_in;
                                if (neff == CNT_W'(1)) begin
                                    done_d = 1'b1;
                                end else begin
                                    state_d = SHIFT;
                                end
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                q_d   = step_q;
                ser_d = step_ser;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            q_q     <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign q       = q_q;
    assign ser_out = ser_q;
    assign busy    = (state_q == SHIFT);
    assign done    = done_q;

endmodule

// File: tb/tb_acc_shift_reg.sv
// Directed bench for acc_shift_reg with hand-computed expected values.
module tb_acc_shift_reg;

    localparam int W     = 16;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [2:0] C_NOP  = 3'b000;
    localparam logic [2:0] C_LOAD = 3'b001;
    localparam logic [2:0] C_SHR  = 3'b010;
    localparam logic [2:0] C_SAR  = 3'b011;
    localparam logic [2:0] C_SHL  = 3'b100;
    localparam logic [2:0] C_ROR  = 3'b101;
    localparam logic [2:0] C_ROL  = 3'b110;
    localparam logic [2:0] C_CLR  = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] amt;
    logic [W:0]       d_in;
    logic             ser_in;
    logic [W:0]       q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    int nbusy;
    int ndone;
    int done_at;

    acc_shift_reg #(.W(W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .amt     (amt),
        .d_in    (d_in),
        .ser_in  (ser_in),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one command into the accept edge; returns 1ns after that edge.
    task automatic cmd(input logic [2:0] o, input logic [CNT_W-1:0] a, input logic [W:0] d);
        start = 1'b1;
        op    = o;
        amt   = a;
        d_in  = d;
        tick();
        start = 1'b0;
        op    = C_NOP;
    endtask

    // Issues a command then observes a fixed window, counting busy/done cycles.
    // A nonnegative inj_at re-asserts start with CLR at that window index.
    task automatic run(input logic [2:0] o, input logic [CNT_W-1:0] a, input int inj_at);
        nbusy   = 0;
        ndone   = 0;
        done_at = -1;
        cmd(o, a, '0);
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            if (i == inj_at) begin
                start = 1'b1;
                op    = C_CLR;
            end
            tick();
            start = 1'b0;
            op    = C_NOP;
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op     = C_NOP;
        amt    = '0;
        d_in   = '0;
        ser_in = 1'b0;
        tick();
        tick();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ser", 32'(ser_out), 32'h0);
        rst = 1'b0;
        tick();

        // LOAD: q updated at accept edge, done in the following cycle only
        cmd(C_LOAD, '0, 17'h1_8001);
        chk("load_q", 32'(q), 32'h1_8001);
        chk("load_done", 32'(done), 32'h1);
        tick();
        chk("load_done_clr", 32'(done), 32'h0);

        // SAR by 3 from 1_8001
        run(C_SAR, 5'd3, -1);
        chk("sar_q", 32'(q), 32'h1_F000);
        chk("sar_ser", 32'(ser_out), 32'h0);
        chk("sar_busy", 32'(nbusy), 32'd2);
        chk("sar_ndone", 32'(ndone), 32'd1);
        chk("sar_done_at", 32'(done_at), 32'd2);

        // SHL by 4 with serial input held high
        cmd(C_LOAD, '0, 17'h0_000F);
        ser_in = 1'b1;
        run(C_SHL, 5'd4, -1);
        chk("shl_q", 32'(q), 32'h0_00FF);
        chk("shl_ser", 32'(ser_out), 32'h0);
        chk("shl_busy", 32'(nbusy), 32'd3);
        ser_in = 1'b0;

        // Zero-amount shift: immediate done, nothing moves
        run(C_SHL, 5'd0, -1);
        chk("shl0_q", 32'(q), 32'h0_00FF);
        chk("shl0_done_at", 32'(done_at), 32'd0);
        chk("shl0_busy", 32'(nbusy), 32'd0);

        // Full rotation returns the original value
        cmd(C_LOAD, '0, 17'h1_A5C3);
        run(C_ROR, 5'd16, -1);
        chk("ror16_q", 32'(q), 32'h1_A5C3);
        chk("ror16_ser", 32'(ser_out), 32'h1);
        chk("ror16_busy", 32'(nbusy), 32'd15);
        chk("ror16_done_at", 32'(done_at), 32'd15);
        run(C_ROL, 5'd4, -1);
        chk("rol4_q", 32'(q), 32'h1_5C3A);
        chk("rol4_ser", 32'(ser_out), 32'h0);

        // Single-step shift: done right after the accept edge, never busy
        cmd(C_LOAD, '0, 17'h0_0003);
        run(C_SHR, 5'd1, -1);
        chk("shr1_q", 32'(q), 32'h0_0001);
        chk("shr1_ser", 32'(ser_out), 32'h1);
        chk("shr1_busy", 32'(nbusy), 32'd0);
        chk("shr1_done_at", 32'(done_at), 32'd0);

        // Over-range amount clamps to W; CLR issued mid-shift is dropped
        cmd(C_LOAD, '0, 17'h0_FFFF);
        run(C_SHR, 5'd20, 2);
        chk("shr20_q", 32'(q), 32'h0_0000);
        chk("shr20_ser", 32'(ser_out), 32'h1);
        chk("shr20_busy", 32'(nbusy), 32'd15);
        chk("shr20_ndone", 32'(ndone), 32'd1);
        chk("shr20_done_at", 32'(done_at), 32'd15);

        // NOP completes without touching q
        cmd(C_LOAD, '0, 17'h1_1234);
        run(C_NOP, 5'd7, -1);
        chk("nop_q", 32'(q), 32'h1_1234);
        chk("nop_done_at", 32'(done_at), 32'd0);

        // CLR also zeroes ser_out
        run(C_CLR, '0, -1);
        chk("clr_q", 32'(q), 32'h0);
        chk("clr_ser", 32'(ser_out), 32'h0);

        // Reset aborts a shift in progress with no done pulse
        cmd(C_LOAD, '0, 17'h0_FFFF);
        cmd(C_SHR, 5'd8, '0);
        tick();
        tick();
        chk("abort_mid_q", 32'(q), 32'h0_1FFF);
        chk("abort_mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_q_hold", 32'(q), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_shift_reg.md
Name: acc_shift_reg

Overview:
Parametrised accumulator/shift register for the ALU16 datapath. It holds a W-bit data field plus one extension bit q[W], used as sign or carry. It supports load, clear, logical and arithmetic right shift, left shift with serial input, and rotates. Multi-position shifts run one position per clock under a start/busy/done handshake, so the multiply/divide control unit can issue "shift by N" as a single command.

Parameters:
W, 16, data field width; the register is W+1 bits including the extension bit q[W].
CNT_W, $clog2(W+1), width of the shift-amount input and the internal counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  command strobe; accepted only when busy=0
op  input  3  command: 000 NOP, 001 LOAD, 010 SHR, 011 SAR, 100 SHL, 101 ROR, 110 ROL, 111 CLR
amt  input  CNT_W  shift amount; ignored for NOP/LOAD/CLR
d_in  input  W+1  parallel load data
ser_in  input  1  serial bit shifted into bit 0 on SHL
q  output  W+1  register contents
ser_out  output  1  registered copy of the bit shifted out on the most recent shift step
busy  output  1  multi-cycle shift in progress
done  output  1  one-cycle pulse after every accepted command completes

Behaviour:
- Reset (rst=1 at a clk edge): q=0, ser_out=0, busy=0, done=0, state=IDLE, counter=0. Reset overrides everything, including a shift in progress; that shift is abandoned with no done pulse.
- Acceptance: a command is accepted at an edge where start=1 and state=IDLE. While busy=1, start is ignored; it is neither queued nor allowed to modify the command in progress.
- States:
  - IDLE: accepting commands.
  - SHIFT: executing the remaining steps using the op latched at acceptance. busy=(state==SHIFT).
- NOP: no change; done=1 in the next cycle.
- LOAD: q<=d_in at the accept edge, including q[W]; done next cycle.
- CLR: q<=0 and ser_out<=0 at the accept edge; done next cycle.
- Shift commands:
  - Neff = min(amt, W).
  - If Neff=0: q is unchanged, ser_out is unchanged, done next cycle.
  - Otherwise the first step happens at the accept edge and the counter is loaded with Neff-1. If Neff>1 the state goes to SHIFT.
  - Each later edge in SHIFT performs one step and decrements the counter. The edge that performs the final step returns the state to IDLE and sets done=1 for one cycle.
  - Net effect: Neff steps at edges E0..E0+Neff-1; busy is high for Neff-1 cycles; done is high for the cycle after E0+Neff-1.
- Single-step definitions. Data field is q[W-1:0]; q[W] is held on every shift step.
  - SHR: q[i]<=q[i+1]; q[W-1]<=0; ser_out<=q[0].
  - SAR: as SHR, but q[W-1] keeps its own value (sign replication).
  - SHL: q[i]<=q[i-1]; q[0]<=ser_in, sampled live at each step edge; ser_out<=q[W-1].
  - ROR: q[W-1]<=q[0]; ser_out<=q[0].
  - ROL: q[0]<=q[W-1]; ser_out<=q[W-1].
- Outputs are registered; no combinational path runs from inputs to outputs.

Decomposition:
- Package acc_shift_pkg holds:
  - op encodings as a 3-bit enum op_t;
  - state enum st_t {IDLE, SHIFT}.
- Sub-module acc_shift_step is purely combinational. Given (q, op, ser_in) it returns the next q and the bit shifted out for one position. The top level instantiates it once and contains the FSM, counter, handshake and registers.

Test Plan:
- rst=1 for 2 cycles, then LOAD d_in=17'h1_8001 -> q=17'h1_8001, done pulses 1 cycle after the accept edge.
- From q=17'h1_8001: SAR amt=3 -> busy=1 for 2 cycles; final q=17'h1_F000, ser_out=0, done pulses once.
- LOAD 17'h0_000F, then SHL amt=4 with ser_in=1 held -> q=17'h0_00FF, ser_out=0, q[16]=0 unchanged.
- LOAD 17'h1_A5C3, ROR amt=16 -> q=17'h1_A5C3 after 16 steps; ROL amt=4 -> q=17'h1_5C3A.
- LOAD 17'h0_FFFF, SHR amt=20 (clamped to 16) -> q=17'h0_0000 after 16 steps. A start with op=CLR issued while busy is ignored (q unchanged by it, no extra done).
- LOAD 17'h0_FFFF, SHR amt=8; assert rst after 3 steps -> next cycle q=0, busy=0, done=0, and no done pulse follows.
